// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: window select, register offsets
// and STATUS bit positions.
package mmio_responder_pkg;

  localparam logic [3:0] MMIO_BASE = 4'h8;
  localparam int         CNT_W     = 32;

  localparam logic [27:0] MMIO_STATUS  = 28'h000_0000;
  localparam logic [27:0] MMIO_RX      = 28'h000_0004;
  localparam logic [27:0] MMIO_TX      = 28'h000_0008;
  localparam logic [27:0] MMIO_CYCLE   = 28'h000_0010;
  localparam logic [27:0] MMIO_INSTR   = 28'h000_0014;
  localparam logic [27:0] MMIO_CNT_RST = 28'h000_0018;

  localparam int STAT_TX_CAN_ACCEPT = 0;
  localparam int STAT_RX_VALID      = 1;

  // Word offset inside the MMIO window; the byte lane bits are ignored.
  function automatic logic [27:0] word_offset(input logic [31:0] addr);
    return addr[27:0] & 28'hFFF_FFFC;
  endfunction

endpackage

// File: rtl/mmio_tx_hold.sv
// One-entry ready/valid holding register feeding the UART transmitter.
module mmio_tx_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       can_accept
);

  logic       full_q, full_d;
  logic [7:0] data_q, data_d;
  logic       drain;
  logic       accept;

  assign drain      = full_q & ready;
  assign can_accept = ~full_q | drain;
  assign accept     = wr_en & can_accept;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = wr_data;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign valid = full_q;
  assign data  = data_q;

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder on the data-memory port: UART tx/rx access, cycle and
// retired-instruction counters, load data returned one cycle after request.
module mmio_responder
  import mmio_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  input  logic        instr_retire,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_data_in_valid,
  input  logic        uart_tx_data_in_ready,
  input  logic [7:0]  uart_rx_data_out,
  input  logic        uart_rx_data_out_valid,
  output logic        uart_rx_data_out_ready
);

  logic             sel;
  logic [27:0]      offset;
  logic             tx_wr;
  logic             cnt_clr;
  logic             tx_can_accept;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      status;

  assign sel     = (addr[31:28] == MMIO_BASE);
  assign offset  = word_offset(addr);
  assign tx_wr   = wen & sel & (offset == MMIO_TX);
  assign cnt_clr = wen & sel & (offset == MMIO_CNT_RST);

  assign uart_rx_data_out_ready = ren & sel & (offset == MMIO_RX) & uart_rx_data_out_valid;

  mmio_tx_hold u_tx_hold (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (tx_wr),
    .wr_data    (wdata[7:0]),
    .ready      (uart_tx_data_in_ready),
    .valid      (uart_tx_data_in_valid),
    .data       (uart_tx_data_in),
    .can_accept (tx_can_accept)
  );

  // A counter clear wins over the increment issued in the same cycle.
  assign cycle_d = cnt_clr ? '0 : cycle_q + 1'b1;
  assign instr_d = cnt_clr ? '0 : instr_q + {{(CNT_W-1){1'b0}}, instr_retire};

  always_comb begin
    status                     = '0;
    status[STAT_TX_CAN_ACCEPT] = tx_can_accept;
    status[STAT_RX_VALID]      = uart_rx_data_out_valid;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (ren && sel) begin
      unique case (offset)
        MMIO_STATUS: rdata_d = status;
        MMIO_RX:     rdata_d = uart_rx_data_out_valid ? {24'h0, uart_rx_data_out} : 32'h0;
        MMIO_CYCLE:  rdata_d = cycle_q;
        MMIO_INSTR:  rdata_d = instr_q;
        default:     rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
      rdata_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with hand-computed expectations.
module tb_mmio_responder;

  localparam logic [31:0] A_STATUS  = 32'h8000_0000;
  localparam logic [31:0] A_RX      = 32'h8000_0004;
  localparam logic [31:0] A_TX      = 32'h8000_0008;
  localparam logic [31:0] A_CYCLE   = 32'h8000_0010;
  localparam logic [31:0] A_INSTR   = 32'h8000_0014;
  localparam logic [31:0] A_CNT_RST = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic        instr_retire;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int n_checks = 0;
  int n_bad    = 0;

  mmio_responder dut (
    .clk                    (clk),
    .rst                    (rst),
    .addr                   (addr),
    .wdata                  (wdata),
    .wen                    (wen),
    .ren                    (ren),
    .instr_retire           (instr_retire),
    .rdata                  (rdata),
    .uart_tx_data_in        (tx_data),
    .uart_tx_data_in_valid  (tx_valid),
    .uart_tx_data_in_ready  (tx_ready),
    .uart_rx_data_out       (rx_data),
    .uart_rx_data_out_valid (rx_valid),
    .uart_rx_data_out_ready (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a;
    ren  = 1'b1;
    tick();
    ren  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
  endtask

  logic [9:0] retire_pat;

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wen = 1'b0; ren = 1'b0;
    instr_retire = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    tick();
    tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);

    // Counters start at 0 after the last reset edge; 5 idle edges give 5.
    rst = 1'b0;
    repeat (5) tick();
    rd(A_CYCLE);
    check("cycle_after_5", rdata, 32'd5);
    rd(A_INSTR);
    check("instr_idle", rdata, 32'd0);

    // TX stalled by the UART
    wr(A_TX, 32'h41);
    check("tx_full_valid", {31'h0, tx_valid}, 32'h1);
    check("tx_full_data", {24'h0, tx_data}, 32'h41);
    tick();
    tick();
    check("tx_stall_valid", {31'h0, tx_valid}, 32'h1);
    check("tx_stall_data", {24'h0, tx_data}, 32'h41);
    rd(A_STATUS);
    check("status_tx_full", rdata, 32'h0);
    wr(A_TX, 32'h42);
    check("tx_drop_data", {24'h0, tx_data}, 32'h41);
    check("tx_drop_valid", {31'h0, tx_valid}, 32'h1);
    tx_ready = 1'b1;
    rd(A_STATUS);
    check("status_drain_accept", rdata, 32'h1);
    check("tx_drained", {31'h0, tx_valid}, 32'h0);

    // Back-to-back writes with ready held high
    wr(A_TX, 32'h41);
    check("b2b_valid0", {31'h0, tx_valid}, 32'h1);
    check("b2b_data0", {24'h0, tx_data}, 32'h41);
    wr(A_TX, 32'h42);
    check("b2b_valid1", {31'h0, tx_valid}, 32'h1);
    check("b2b_data1", {24'h0, tx_data}, 32'h42);
    tick();
    check("b2b_empty", {31'h0, tx_valid}, 32'h0);

    // RX pop, with the tx register held FULL so STATUS bit0 is 0
    tx_ready = 1'b0;
    wr(A_TX, 32'h55);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    rd(A_STATUS);
    check("status_rx_valid", rdata, 32'h2);
    addr = A_RX;
    ren  = 1'b1;
    #1;
    check("rx_pop_ready", {31'h0, rx_ready}, 32'h1);
    tick();
    ren      = 1'b0;
    rx_valid = 1'b0;
    check("rx_pop_data", rdata, 32'h5A);
    #1;
    check("rx_pop_one_cycle", {31'h0, rx_ready}, 32'h0);
    addr = A_RX;
    ren  = 1'b1;
    #1;
    check("rx_empty_no_pop", {31'h0, rx_ready}, 32'h0);
    tick();
    ren = 1'b0;
    check("rx_empty_data", rdata, 32'h0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("tx_55_drained", {31'h0, tx_valid}, 32'h0);

    // Retired-instruction count: 7 pulses over 10 cycles
    wr(A_CNT_RST, 32'h0);
    retire_pat = 10'b10_1101_1011;
    for (int i = 0; i < 10; i++) begin
      instr_retire = retire_pat[i];
      tick();
    end
    instr_retire = 1'b0;
    rd(A_INSTR);
    check("instr_7", rdata, 32'd7);

    // Clear coincident with a retire pulse: clear wins, then counting resumes
    instr_retire = 1'b1;
    wr(A_CNT_RST, 32'h0);
    instr_retire = 1'b0;
    rd(A_CYCLE);
    check("clr_cycle", rdata, 32'd0);
    rd(A_INSTR);
    check("clr_instr", rdata, 32'd0);
    rd(A_CYCLE);
    check("cycle_resume", rdata, 32'd2);

    // Wrap of the cycle counter
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    addr = A_CYCLE;
    ren  = 1'b1;
    tick();
    check("wrap_m2", rdata, 32'hFFFF_FFFE);
    tick();
    check("wrap_m1", rdata, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", rdata, 32'h0);
    ren = 1'b0;

    // Unmapped offsets, non-MMIO accesses, stores to read-only registers
    rd(A_STATUS);
    check("status_idle", rdata, 32'h1);
    rd(32'h0000_0010);
    check("non_mmio_hold", rdata, 32'h1);
    rd(32'h8000_0020);
    check("unmapped_read", rdata, 32'h0);
    rx_valid = 1'b1;
    addr  = A_RX;
    wdata = 32'hFF;
    wen   = 1'b1;
    #1;
    check("store_rx_no_pop", {31'h0, rx_ready}, 32'h0);
    tick();
    wen = 1'b0;
    rx_valid = 1'b0;
    check("store_rx_no_tx", {31'h0, tx_valid}, 32'h0);
    wr(32'h0000_0008, 32'h66);
    check("non_mmio_store", {31'h0, tx_valid}, 32'h0);

    // Reset with a pending tx byte
    wr(A_TX, 32'h77);
    check("pre_rst_full", {31'h0, tx_valid}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_mid_data", {24'h0, tx_data}, 32'h0);
    rd(A_CYCLE);
    check("rst_mid_cycle", rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
